mp_mult_engine: RTL and testbench

- Memory-mapped multi-precision multiply accelerator that sits beside the byte-wide data memory (dm) under top_level.
- On a req/done handshake it walks NUM_PAIRS operand pairs, each operand OP_BYTES wide, and multiplies each pair as signed or unsigned.
- Each 2*OP_BYTES-byte product is written back big-endian.
- It generalises the fixed 16-pair, 16-bit signed product program to any width, any pair count, and a selectable signedness mode.

---
 rtl/mp_mult_engine_if.sv | 24 ++
 rtl/mp_mult_engine.sv | 167 ++++++++++++++++
 tb/tb_mp_mult_engine.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mp_mult_engine_if.sv
// Host/data-memory bundle for mp_mult_engine: start/done handshake plus the byte-wide dm port.
// master = host side (drives req and memory read data), slave = engine side.
interface mp_mult_engine_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              req;
    logic              signed_mode;
    logic              done;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rd_data;
    logic              mem_wr_en;
    logic [7:0]        mem_wr_data;

    modport master (
        output req, signed_mode, mem_rd_data,
        input  done, busy, mem_addr, mem_wr_en, mem_wr_data
    );

    modport slave (
        input  req, signed_mode, mem_rd_data,
        output done, busy, mem_addr, mem_wr_en, mem_wr_data
    );
endinterface

// File: rtl/mp_mult_engine.sv
// Multi-precision multiply engine: loads NUM_PAIRS operand pairs from dm, multiplies each by
// radix-2 shift-add on magnitudes (signed or unsigned) and writes the 2W-bit product MSB first.
module mp_mult_engine #(
    parameter int unsigned OP_BYTES  = 2,
    parameter int unsigned NUM_PAIRS = 16,
    parameter int unsigned SRC_BASE  = 0,
    parameter int unsigned DST_BASE  = 64,
    parameter int unsigned ADDR_W    = 8
) (
    input logic              clk,
    input logic              reset,
    mp_mult_engine_if.slave  bus
);

    localparam int unsigned W  = 8 * OP_BYTES;
    localparam int unsigned PB = 2 * OP_BYTES;
    localparam int unsigned PW = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
    localparam int unsigned CW = 7;

    localparam logic [CW-1:0] LoadLast = CW'(PB - 1);
    localparam logic [CW-1:0] MulLast  = CW'(W - 1);
    localparam logic [PW-1:0] PairLast = PW'(NUM_PAIRS - 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StLoad  = 3'd1;
    localparam logic [2:0] StMul   = 3'd2;
    localparam logic [2:0] StStore = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    // Regions are compared on the address circle, since addresses wrap modulo 2^ADDR_W.
    localparam longint unsigned MemBytes = 64'd1 << ADDR_W;
    localparam longint unsigned RegBytes = longint'(NUM_PAIRS) * longint'(PB);
    localparam longint unsigned SrcM     = longint'(SRC_BASE) % MemBytes;
    localparam longint unsigned DstM     = longint'(DST_BASE) % MemBytes;
    localparam longint unsigned FwdGap   = (DstM + MemBytes - SrcM) % MemBytes;
    localparam longint unsigned BwdGap   = (SrcM + MemBytes - DstM) % MemBytes;

    if (OP_BYTES < 1 || OP_BYTES > 8 || NUM_PAIRS < 1) begin : g_bad_params
        $error("mp_mult_engine: OP_BYTES must be 1..8 and NUM_PAIRS at least 1");
    end
    if (RegBytes > MemBytes) begin : g_bad_size
        $error("mp_mult_engine: operand/product region larger than the address space");
    end
    if (FwdGap < RegBytes || BwdGap < RegBytes) begin : g_bad_overlap
        $error("mp_mult_engine: source and destination regions overlap");
    end

    logic [2:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   pair_q, pair_d;
    logic            mode_q, mode_d;
    logic            neg_q, neg_d;
    logic            done_q, done_d;
    logic [2*W-1:0]  opnd_q, opnd_d;
    logic [2*W-1:0]  prod_q, prod_d;

    logic [2*W-1:0]    load_shift;
    logic [W-1:0]      a_raw, b_next, mag_a, mag_b_next;
    logic [W:0]        step_sum;
    logic [2*W-1:0]    step_prod;
    logic [ADDR_W-1:0] pair_off, rd_addr, wr_addr;

    assign load_shift = {opnd_q[2*W-9:0], bus.mem_rd_data};
    assign a_raw      = opnd_q[2*W-1:W];
    assign b_next     = load_shift[W-1:0];
    assign mag_a      = (mode_q && a_raw[W-1]) ? -a_raw : a_raw;
    assign mag_b_next = (mode_q && b_next[W-1]) ? -b_next : b_next;

    // One shift-add step: multiplier sits in the low half of prod and drains out to the right.
    assign step_sum  = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mag_a} : '0);
    assign step_prod = {step_sum, prod_q[W-1:1]};

    assign pair_off = ADDR_W'(PB) * ADDR_W'(pair_q);
    assign rd_addr  = ADDR_W'(SRC_BASE) + pair_off + ADDR_W'(cnt_q);
    assign wr_addr  = ADDR_W'(DST_BASE) + pair_off + ADDR_W'(cnt_q);

    assign bus.done        = done_q;
    assign bus.busy        = (state_q == StLoad) || (state_q == StMul) || (state_q == StStore);
    assign bus.mem_wr_en   = (state_q == StStore);
    assign bus.mem_wr_data = (state_q == StStore) ? prod_q[2*W-1 -: 8] : 8'h00;
    assign bus.mem_addr    = (state_q == StLoad)  ? rd_addr :
                             (state_q == StStore) ? wr_addr : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pair_d  = pair_q;
        mode_d  = mode_q;
        neg_d   = neg_q;
        opnd_d  = opnd_q;
        prod_d  = prod_q;
        // done rises the cycle after DONE is entered and drops on the edge that sees req low.
        done_d  = (state_q == StDone) && bus.req;

        case (state_q)
            StIdle: begin
                if (bus.req && !done_q) begin
                    mode_d  = bus.signed_mode;
                    pair_d  = '0;
                    cnt_d   = '0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                opnd_d = load_shift;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LoadLast) begin
                    cnt_d   = '0;
                    prod_d  = {{W{1'b0}}, mag_b_next};
                    neg_d   = mode_q && (load_shift[2*W-1] ^ load_shift[W-1]);
                    state_d = StMul;
                end
            end
            StMul: begin
                prod_d = step_prod;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == MulLast) begin
                    prod_d  = neg_q ? -step_prod : step_prod;
                    cnt_d   = '0;
                    state_d = StStore;
                end
            end
            StStore: begin
                prod_d = prod_q << 8;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LoadLast) begin
                    cnt_d = '0;
                    if (pair_q == PairLast) begin
                        state_d = StDone;
                    end else begin
                        pair_d  = pair_q + 1'b1;
                        state_d = StLoad;
                    end
                end
            end
            StDone: begin
                if (!bus.req) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pair_q  <= '0;
            mode_q  <= 1'b0;
            neg_q   <= 1'b0;
            done_q  <= 1'b0;
            opnd_q  <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pair_q  <= pair_d;
            mode_q  <= mode_d;
            neg_q   <= neg_d;
            done_q  <= done_d;
            opnd_q  <= opnd_d;
            prod_q  <= prod_d;
        end
    end

endmodule

// File: tb/tb_mp_mult_engine.sv
// Directed and randomised checks of mp_mult_engine against a behavioural multiply model,
// using a default instance (16x16-bit) and a 32-bit, two-pair instance.
module tb_mp_mult_engine;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mp_mult_engine_if #(.ADDR_W(8)) bus1 ();
    mp_mult_engine_if #(.ADDR_W(8)) bus2 ();

    mp_mult_engine u_dut1 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus1)
    );

    mp_mult_engine #(
        .OP_BYTES  (4),
        .NUM_PAIRS (2),
        .DST_BASE  (16)
    ) u_dut2 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus2)
    );

    logic [7:0] mem1 [256];
    logic [7:0] mem2 [256];
    int wr_cnt1 = 0;

    assign bus1.mem_rd_data = mem1[bus1.mem_addr];
    assign bus2.mem_rd_data = mem2[bus2.mem_addr];

    always @(posedge clk) begin
        if (bus1.mem_wr_en) begin
            mem1[bus1.mem_addr] <= bus1.mem_wr_data;
            wr_cnt1 <= wr_cnt1 + 1;
        end
        if (bus2.mem_wr_en) mem2[bus2.mem_addr] <= bus2.mem_wr_data;
    end

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [31:0] gold1(input logic [15:0] a, input logic [15:0] b,
                                          input bit sm);
        int sa, sb;
        int unsigned ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        return sm ? 32'(sa * sb) : (ua * ub);
    endfunction

    function automatic logic [31:0] got1(input int j);
        return {mem1[64+4*j], mem1[65+4*j], mem1[66+4*j], mem1[67+4*j]};
    endfunction

    task automatic set_pair1(input int j, input logic [15:0] a, input logic [15:0] b);
        mem1[4*j]   = a[15:8];
        mem1[4*j+1] = a[7:0];
        mem1[4*j+2] = b[15:8];
        mem1[4*j+3] = b[7:0];
    endtask

    task automatic clear_mem1();
        for (int i = 0; i < 256; i++) mem1[i] = (i >= 64 && i < 128) ? 8'hAA : 8'h00;
    endtask

    task automatic poison_dst1();
        for (int i = 64; i < 128; i++) mem1[i] = 8'hAA;
    endtask

    task automatic check_all1(input string name, input bit sm);
        logic [31:0] exp;
        for (int j = 0; j < 16; j++) begin
            exp = gold1({mem1[4*j], mem1[4*j+1]}, {mem1[4*j+2], mem1[4*j+3]}, sm);
            vectors++;
            if (got1(j) !== exp) begin
                miscompares++;
                $display("FAIL %s pair%0d: got %08h expected %08h", name, j, got1(j), exp);
            end
        end
    endtask

    task automatic run_job1(input bit sm, output int edges);
        @(negedge clk);
        bus1.signed_mode = sm;
        bus1.req = 1'b1;
        @(posedge clk);
        edges = 0;
        while (edges < 5000) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus1.done === 1'b1) break;
        end
        if (bus1.done !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL job1_timeout: done=%b after %0d edges, required 1", bus1.done, edges);
        end
    endtask

    task automatic end_job1(input string name);
        @(negedge clk);
        bus1.req = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (bus1.done !== 1'b0 || bus1.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_release: done=%b busy=%b, required 0 0", name, bus1.done,
                     bus1.busy);
        end
    endtask

    task automatic check_edges(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s_latency: done after %0d edges, required %0d", name, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        vectors++;
        if ({bus1.done, bus1.busy, bus1.mem_wr_en, bus1.mem_addr, bus1.mem_wr_data} !== 19'd0) begin
            miscompares++;
            $display("FAIL %s dut1: done=%b busy=%b we=%b addr=%h wd=%h, required all 0", name,
                     bus1.done, bus1.busy, bus1.mem_wr_en, bus1.mem_addr, bus1.mem_wr_data);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #3;
        rst_n = 1'b0;
        #2;
        check_idle_outputs("reset");
        vectors++;
        if ({bus2.done, bus2.busy, bus2.mem_wr_en, bus2.mem_addr, bus2.mem_wr_data} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset dut2: done=%b busy=%b we=%b addr=%h wd=%h, required all 0",
                     bus2.done, bus2.busy, bus2.mem_wr_en, bus2.mem_addr, bus2.mem_wr_data);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_signed_directed();
        int e;
        clear_mem1();
        set_pair1(0, 16'd3, 16'hFFF9);
        set_pair1(1, 16'h8000, 16'h8000);
        run_job1(1'b1, e);
        check_edges("signed16", e, 385);
        vectors++;
        if (got1(0) !== 32'hFFFF_FFEB) begin
            miscompares++;
            $display("FAIL signed16_p0: got %08h expected FFFFFFEB", got1(0));
        end
        vectors++;
        if (got1(1) !== 32'h4000_0000) begin
            miscompares++;
            $display("FAIL signed16_p1: got %08h expected 40000000", got1(1));
        end
        check_all1("signed16", 1'b1);
        end_job1("signed16");
    endtask

    task automatic test_unsigned_vs_signed();
        int e;
        clear_mem1();
        set_pair1(0, 16'hFFFF, 16'hFFFF);
        run_job1(1'b0, e);
        vectors++;
        if (got1(0) !== 32'hFFFE_0001) begin
            miscompares++;
            $display("FAIL unsigned_ffff: got %08h expected FFFE0001", got1(0));
        end
        check_all1("unsigned_ffff", 1'b0);
        end_job1("unsigned_ffff");
        poison_dst1();
        run_job1(1'b1, e);
        vectors++;
        if (got1(0) !== 32'h0000_0001) begin
            miscompares++;
            $display("FAIL signed_ffff: got %08h expected 00000001", got1(0));
        end
        end_job1("signed_ffff");
    endtask

    task automatic test_wide();
        int e;
        logic [63:0] p0, p1;
        for (int i = 0; i < 256; i++) mem2[i] = (i >= 16 && i < 32) ? 8'hAA : 8'h00;
        {mem2[0], mem2[1], mem2[2], mem2[3]}     = 32'hFFFF_FFFF;
        {mem2[4], mem2[5], mem2[6], mem2[7]}     = 32'h7FFF_FFFF;
        {mem2[8], mem2[9], mem2[10], mem2[11]}   = 32'h8000_0000;
        {mem2[12], mem2[13], mem2[14], mem2[15]} = 32'h0000_0002;
        @(negedge clk);
        bus2.signed_mode = 1'b1;
        bus2.req = 1'b1;
        @(posedge clk);
        e = 0;
        while (e < 2000) begin
            @(posedge clk);
            #1;
            e++;
            if (bus2.done === 1'b1) break;
        end
        check_edges("wide32", e, 97);
        p0 = {mem2[16], mem2[17], mem2[18], mem2[19], mem2[20], mem2[21], mem2[22], mem2[23]};
        p1 = {mem2[24], mem2[25], mem2[26], mem2[27], mem2[28], mem2[29], mem2[30], mem2[31]};
        vectors++;
        if (p0 !== 64'hFFFF_FFFF_8000_0001) begin
            miscompares++;
            $display("FAIL wide32_p0: got %016h expected FFFFFFFF80000001", p0);
        end
        vectors++;
        if (p1 !== 64'hFFFF_FFFF_0000_0000) begin
            miscompares++;
            $display("FAIL wide32_p1: got %016h expected FFFFFFFF00000000", p1);
        end
        @(negedge clk);
        bus2.req = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (bus2.done !== 1'b0) begin
            miscompares++;
            $display("FAIL wide32_release: done=%b, required 0", bus2.done);
        end
    endtask

    task automatic test_reset_mid_store();
        int e, wc, cyc;
        clear_mem1();
        for (int j = 0; j < 16; j++) set_pair1(j, 16'($urandom()), 16'($urandom()));
        @(negedge clk);
        bus1.signed_mode = 1'b1;
        bus1.req = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!(bus1.mem_wr_en === 1'b1 && bus1.mem_addr === 8'd84) && cyc < 2000);
        vectors++;
        if (cyc >= 2000) begin
            miscompares++;
            $display("FAIL midreset_reach: pair5 store not seen in %0d cycles, required <2000",
                     cyc);
        end
        @(negedge clk);
        rst_n = 1'b0;
        bus1.req = 1'b0;
        #1;
        check_idle_outputs("midreset_async");
        wc = wr_cnt1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        vectors++;
        if (wr_cnt1 != wc) begin
            miscompares++;
            $display("FAIL midreset_writes: %0d writes after reset, required 0", wr_cnt1 - wc);
        end
        check_idle_outputs("midreset_idle");
        poison_dst1();
        run_job1(1'b1, e);
        check_edges("midreset_rerun", e, 385);
        check_all1("midreset_rerun", 1'b1);
        end_job1("midreset_rerun");
    endtask

    task automatic test_hold_req();
        int e, wc;
        clear_mem1();
        set_pair1(0, 16'h1234, 16'hFEDC);
        set_pair1(15, 16'h7FFF, 16'h8000);
        run_job1(1'b1, e);
        check_all1("hold_first", 1'b1);
        wc = wr_cnt1;
        repeat (50) @(posedge clk);
        #1;
        vectors++;
        if (wr_cnt1 != wc || bus1.done !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_req: %0d writes done=%b, required 0 writes done=1",
                     wr_cnt1 - wc, bus1.done);
        end
        end_job1("hold_req");
        poison_dst1();
        run_job1(1'b1, e);
        check_edges("hold_rerun", e, 385);
        check_all1("hold_rerun", 1'b1);
        end_job1("hold_rerun");
    endtask

    task automatic test_random();
        int e;
        bit sm;
        for (int it = 0; it < 10; it++) begin
            sm = it[0];
            clear_mem1();
            for (int j = 0; j < 16; j++) set_pair1(j, 16'($urandom()), 16'($urandom()));
            if (it == 2) set_pair1(3, 16'h8000, 16'h0000);
            run_job1(sm, e);
            check_all1(sm ? "random_signed" : "random_unsigned", sm);
            end_job1("random");
        end
    endtask

    initial begin
        bus1.req = 1'b0;
        bus1.signed_mode = 1'b0;
        bus2.req = 1'b0;
        bus2.signed_mode = 1'b0;
        clear_mem1();
        for (int i = 0; i < 256; i++) mem2[i] = 8'h00;
        test_reset();
        test_signed_directed();
        test_unsigned_vs_signed();
        test_wide();
        test_reset_mid_store();
        test_hold_req();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
